// File: rtl/instr_mem_64x32_pkg.sv
// Shared types, geometry and boot image for the 64x32 instruction memory.
// The image is built from named MIPS-style encodings so the boot program reads as code.
package instr_mem_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] instr_t;
    typedef logic [ADDR_W-1:0] imem_addr_t;
    typedef instr_t [DEPTH-1:0] imem_t;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] FUNCT_ADD = 6'h20;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_T0   = 5'd8;
    localparam logic [4:0] REG_T1   = 5'd9;
    localparam logic [4:0] REG_T2   = 5'd10;

    localparam instr_t INSTR_NOP = '0;

    function automatic instr_t enc_i(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic instr_t enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    // $t0 = 5; $t1 = 10; $t2 = $t0 + $t1; remainder is nops.
    function automatic imem_t build_image();
        imem_t img;
        img    = '{default: INSTR_NOP};
        img[0] = enc_i(OP_ADDI, REG_ZERO, REG_T0, 16'd5);
        img[1] = enc_i(OP_ADDI, REG_ZERO, REG_T1, 16'd10);
        img[2] = enc_r(REG_T0, REG_T1, REG_T2, FUNCT_ADD);
        return img;
    endfunction

    localparam imem_t IMEM_INIT = build_image();

endpackage

// File: rtl/instr_mem_64x32_if.sv
// Fetch-side read bus plus optional program-load port of the instruction memory.
// The load signals exist only when IMEM_WRITE_EN is defined.
interface instr_mem_64x32_if;
    import instr_mem_pkg::*;

    imem_addr_t a;
    instr_t     readdata;
`ifdef IMEM_WRITE_EN
    logic       we;
    imem_addr_t wa;
    instr_t     wd;

    modport master (output a, output we, output wa, output wd, input readdata);
    modport slave  (input a, input we, input wa, input wd, output readdata);
`else
    modport master (output a, input readdata);
    modport slave  (input a, output readdata);
`endif

endinterface

// File: rtl/instr_mem_64x32.sv
// Purpose: 64x32 word-addressed instruction memory; writable image when IMEM_WRITE_EN, else ROM.
// Latency: read is combinational (zero cycles); program-load writes land on the rising clk edge.
// Backpressure: none; every address is always readable and every write is accepted.
module instr_mem_64x32
    import instr_mem_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    instr_mem_64x32_if.slave bus
);

`ifdef IMEM_WRITE_EN
    // Declaration initialiser makes the image valid before the first clock or reset.
    imem_t r_mem = IMEM_INIT;

    // Reset reloads the whole image and takes priority over a same-edge load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem <= IMEM_INIT;
        end else if (bus.we) begin
            r_mem[bus.wa] <= bus.wd;
        end
    end

    assign bus.readdata = r_mem[bus.a];
`else
    logic w_unused_ok;

    assign bus.readdata = IMEM_INIT[bus.a];
    // clk/rst_n kept for a uniform port list; the ROM never uses them.
    assign w_unused_ok  = &{1'b0, clk, rst_n};
`endif

endmodule

// File: tb/tb_instr_mem_64x32.sv
// Directed bench for instr_mem_64x32; load/reset-priority scenarios run when IMEM_WRITE_EN is defined.
module tb_instr_mem_64x32;

    logic clk;
    logic rst_n;
    logic clk_en;
    int   vec_cnt;
    int   err_cnt;

    instr_mem_64x32_if bus ();

    instr_mem_64x32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = clk_en ? ~clk : clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Hand-encoded boot program: addi $t0,$0,5 / addi $t1,$0,10 / add $t2,$t0,$t1 / nops.
    function automatic logic [31:0] boot_word(input int idx);
        case (idx)
            0:       return 32'h2008_0005;
            1:       return 32'h2009_000A;
            2:       return 32'h0109_5020;
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic sweep(input string tag);
        for (int i = 0; i < 64; i++) begin
            bus.a = 6'(i);
            #1;
            chk($sformatf("%s a=%0d", tag, i), bus.readdata, boot_word(i));
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        clk     = 1'b0;
        clk_en  = 1'b0;
        rst_n   = 1'b1;
        bus.a   = '0;
`ifdef IMEM_WRITE_EN
        bus.we  = 1'b0;
        bus.wa  = '0;
        bus.wd  = '0;
`endif

        // Image readable before any clock edge or reset.
        #10;
        chk("pre_clk a=0", bus.readdata, 32'h2008_0005);
        bus.a = 6'd1;
        #10;
        chk("pre_clk a=1", bus.readdata, 32'h2009_000A);
        sweep("pre_clk_sweep");

        clk_en = 1'b1;
        @(negedge clk);

`ifdef IMEM_WRITE_EN
        // Single-word load touches only its target.
        bus.we = 1'b1;
        bus.wa = 6'd5;
        bus.wd = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        bus.a  = 6'd5;
        #1;
        chk("load a=5", bus.readdata, 32'hDEAD_BEEF);
        bus.a = 6'd4;
        #1;
        chk("load a=4", bus.readdata, 32'h0000_0000);
        bus.a = 6'd6;
        #1;
        chk("load a=6", bus.readdata, 32'h0000_0000);

        // Read-during-write: old word until the edge, no bypass.
        @(negedge clk);
        bus.a  = 6'd1;
        bus.wa = 6'd1;
        bus.wd = 32'h1234_5678;
        bus.we = 1'b1;
        #1;
        chk("rdw before edge", bus.readdata, 32'h2009_000A);
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        chk("rdw after edge", bus.readdata, 32'h1234_5678);

        // Reset with a concurrent load: reset wins, all loaded words revert.
        @(negedge clk);
        rst_n  = 1'b0;
        bus.we = 1'b1;
        bus.wa = 6'd0;
        bus.wd = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        bus.we = 1'b0;
        bus.a  = 6'd0;
        #1;
        chk("rst_vs_wr a=0", bus.readdata, 32'h2008_0005);
        bus.a = 6'd5;
        #1;
        chk("rst_vs_wr a=5", bus.readdata, 32'h0000_0000);
        bus.a = 6'd1;
        #1;
        chk("rst_vs_wr a=1", bus.readdata, 32'h2009_000A);

        // Idle clocks with we low must hold contents.
        repeat (3) @(posedge clk);
        #1;
        bus.a = 6'd63;
        bus.wa = 6'd63;
        bus.wd = 32'hA5A5_5A5A;
        #1;
        chk("we_low hold a=63", bus.readdata, 32'h0000_0000);
        @(negedge clk);
        bus.we = 1'b1;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        chk("load a=63", bus.readdata, 32'hA5A5_5A5A);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep("post_reset_sweep");
`else
        // ROM ignores clock and reset activity.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sweep("rst_low_sweep");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sweep("rst_high_sweep");
`endif

        clk_en = 1'b0;
        #10;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
